// File: rtl/manhattan_update_sequencer.sv
// Walks one Manhattan weight-update pass over NUM_WEIGHTS entries:
// read, latch, let the combinational update block settle, write back.
module manhattan_update_sequencer #(
    parameter int BIT_WIDTH   = 32,
    parameter int EXTRA_BIT   = 2,
    parameter int NUM_WEIGHTS = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int CALC_CYCLES = 2,
    localparam int W = BIT_WIDTH + EXTRA_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [W-1:0]          eta_in,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [W-1:0]          weight_rd_data,
    input  logic [W-1:0]          error_rd_data,
    output logic                  man_enable,
    output logic [W-1:0]          man_old_weight,
    output logic [W-1:0]          man_diff_error,
    output logic [W-1:0]          man_eta,
    input  logic [W-1:0]          man_updated,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [W-1:0]          mem_wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CW-1:0]         CALC_LAST = CW'(CALC_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_WEIGHTS - 1);

    typedef enum logic [2:0] {IDLE, RD, LAT, CALC, WR, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CW-1:0]         calc_cnt;
    logic                  wr_pend;

    // An abort landing in the WR cycle itself must kill that write.
    assign mem_wr_en = wr_pend & ~abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr           <= '0;
            calc_cnt       <= '0;
            wr_pend        <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_rd_addr    <= '0;
            man_enable     <= 1'b0;
            man_old_weight <= '0;
            man_diff_error <= '0;
            man_eta        <= '0;
            mem_wr_addr    <= '0;
            mem_wr_data    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            calc_cnt   <= '0;
            wr_pend    <= 1'b0;
            mem_rd_en  <= 1'b0;
            man_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            wr_pend   <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        man_eta     <= eta_in;
                        addr        <= '0;
                        mem_rd_addr <= '0;
                        mem_rd_en   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= RD;
                    end
                end
                RD: state <= LAT;
                LAT: begin
                    man_old_weight <= weight_rd_data;
                    man_diff_error <= error_rd_data;
                    man_enable     <= 1'b1;
                    calc_cnt       <= '0;
                    state          <= CALC;
                end
                CALC: begin
                    if (calc_cnt == CALC_LAST) begin
                        mem_wr_data <= man_updated;
                        mem_wr_addr <= addr;
                        wr_pend     <= 1'b1;
                        calc_cnt    <= '0;
                        state       <= WR;
                    end else begin
                        calc_cnt <= calc_cnt + CW'(1);
                    end
                end
                WR: begin
                    man_enable <= 1'b0;
                    if (addr == ADDR_LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr        <= addr + ADDR_WIDTH'(1);
                        mem_rd_addr <= addr + ADDR_WIDTH'(1);
                        mem_rd_en   <= 1'b1;
                        state       <= RD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_manhattan_update_sequencer.sv
// Bench for manhattan_update_sequencer: write scoreboard with a +1 Manhattan stub,
// a 4-entry/2-settle instance and a 1-entry/1-settle instance.
module tb_manhattan_update_sequencer;

    localparam int W  = 34;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          start, abort;
    logic [W-1:0]  eta_in;
    logic          mem_rd_en, mem_wr_en, man_enable, busy, done;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [W-1:0]  weight_rd_data, error_rd_data, man_old_weight, man_diff_error;
    logic [W-1:0]  man_eta, man_updated, mem_wr_data;

    logic          start1;
    logic [W-1:0]  eta1;
    logic          mem_rd_en1, mem_wr_en1, man_enable1, busy1, done1;
    logic [AW-1:0] mem_rd_addr1, mem_wr_addr1;
    logic [W-1:0]  weight_rd_data1, error_rd_data1, man_old_weight1, man_diff_error1;
    logic [W-1:0]  man_eta1, man_updated1, mem_wr_data1;

    manhattan_update_sequencer #(.BIT_WIDTH(32), .EXTRA_BIT(2), .NUM_WEIGHTS(4),
                                 .ADDR_WIDTH(AW), .CALC_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eta_in(eta_in),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .weight_rd_data(weight_rd_data), .error_rd_data(error_rd_data),
        .man_enable(man_enable), .man_old_weight(man_old_weight),
        .man_diff_error(man_diff_error), .man_eta(man_eta), .man_updated(man_updated),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done)
    );

    manhattan_update_sequencer #(.BIT_WIDTH(32), .EXTRA_BIT(2), .NUM_WEIGHTS(1),
                                 .ADDR_WIDTH(AW), .CALC_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .eta_in(eta1),
        .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr1),
        .weight_rd_data(weight_rd_data1), .error_rd_data(error_rd_data1),
        .man_enable(man_enable1), .man_old_weight(man_old_weight1),
        .man_diff_error(man_diff_error1), .man_eta(man_eta1), .man_updated(man_updated1),
        .mem_wr_en(mem_wr_en1), .mem_wr_addr(mem_wr_addr1), .mem_wr_data(mem_wr_data1),
        .busy(busy1), .done(done1)
    );

    // Manhattan stub and synchronous memories
    assign man_updated  = man_enable  ? man_old_weight  + W'(1) : '0;
    assign man_updated1 = man_enable1 ? man_old_weight1 + W'(1) : '0;

    logic [W-1:0] wmem [16];
    logic [W-1:0] emem [16];
    logic [W-1:0] w1, e1;

    initial begin
        for (int i = 0; i < 16; i++) begin
            wmem[i] <= W'(i);
            emem[i] <= W'(256 + i);
        end
        w1 <= W'(7);
        e1 <= W'(85);
    end

    always @(posedge clk) begin
        if (mem_rd_en) begin
            weight_rd_data <= wmem[mem_rd_addr];
            error_rd_data  <= emem[mem_rd_addr];
        end
        if (mem_wr_en) wmem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en1) begin
            weight_rd_data1 <= w1;
            error_rd_data1  <= e1;
        end
        if (mem_wr_en1) w1 <= mem_wr_data1;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [W-1:0]  err;
    } wr_t;

    wr_t          exp_q[$];
    wr_t          exp1_q[$];
    logic [W-1:0] exp_eta;
    int           errors = 0;
    int           checks = 0;
    int           en1_cnt = 0;
    int           rd1_cnt = 0;
    int           seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int a, input logic [W-1:0] d, input logic [W-1:0] e);
        wr_t x;
        x.addr = AW'(a);
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Monitor: pops the scoreboard on every write strobe seen by the memory
    always @(negedge clk) begin
        wr_t e;
        if (mem_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: addr=%0d data=%h, no write expected",
                         mem_wr_addr, mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wr_data), 64'(e.data));
                chk("wr_diff_error", 64'(man_diff_error), 64'(e.err));
            end
        end
        if (mem_rd_en || mem_wr_en) chk("rd_wr_overlap", 64'(mem_rd_en & mem_wr_en), 64'(0));
        if (busy) chk("man_eta", 64'(man_eta), 64'(exp_eta));
        if (mem_wr_en1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr1: data=%h, no write expected", mem_wr_data1);
            end else begin
                e = exp1_q.pop_front();
                chk("wr1_addr", 64'(mem_wr_addr1), 64'(e.addr));
                chk("wr1_data", 64'(mem_wr_data1), 64'(e.data));
            end
        end
        if (man_enable1) en1_cnt++;
        if (mem_rd_en1)  rd1_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge in cycle c0; counts negedges up to done.
    task automatic wait_done(input bit which, input int exp, input int c0, input string nm);
        int k;
        k = c0;
        @(negedge clk);
        while (!(which ? done1 : done) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 64'(k), 64'(exp));
        @(negedge clk);
        chk({nm, "_busy_after"}, 64'(which ? busy1 : busy), 64'(0));
        chk({nm, "_pulse_width"}, 64'(which ? done1 : done), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        start = 0; abort = 0; eta_in = '0; start1 = 0; eta1 = '0; exp_eta = '0;
        #1 rst_n = 0;
        #11;
        chk("reset_strobes", 64'({busy, done, mem_rd_en, mem_wr_en, man_enable}), 64'(0));
        chk("reset_eta", 64'(man_eta), 64'(0));
        chk("reset_data", 64'(man_old_weight | man_diff_error | mem_wr_data), 64'(0));
        chk("reset_addr", 64'({mem_rd_addr, mem_wr_addr}), 64'(0));
        @(posedge clk); #1 rst_n = 1;
        step(2);

        // Basic pass with eta latched and then changed mid-pass
        exp_eta = 34'h1_3DCCCCCD;
        eta_in  = 34'h1_3DCCCCCD;
        for (int i = 0; i < 4; i++) push(i, W'(i + 1), W'(256 + i));
        start = 1; step(1); start = 0;
        step(5);
        eta_in = 34'h1_3F800000;
        wait_done(0, 20, 5, "done_basic");
        chk("basic_all_writes", 64'(exp_q.size()), 64'(0));

        // start held through a pass, then a second pass with stray start pulses
        exp_eta = 34'h1_3F800000;
        for (int i = 0; i < 4; i++) push(i, W'(i + 2), W'(256 + i));
        for (int i = 0; i < 4; i++) push(i, W'(i + 3), W'(256 + i));
        start = 1; step(1);
        wait_done(0, 20, 0, "done_held");
        start = 0; step(7);
        start = 1; step(1); start = 0; step(5);
        start = 1; step(1); start = 0;
        wait_done(0, 20, 14, "done_pulsed");
        chk("pulsed_all_writes", 64'(exp_q.size()), 64'(0));

        // abort in the WR cycle of addr 2
        exp_eta = 34'h0_12345678;
        eta_in  = 34'h0_12345678;
        push(0, W'(4), W'(256));
        push(1, W'(5), W'(257));
        start = 1; step(1); start = 0;
        step(14);
        abort = 1; step(1); abort = 0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_idle_strobes", 64'({mem_rd_en, man_enable, done}), 64'(0));
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        chk("abort_addr2_kept", 64'(wmem[2]), 64'(5));
        chk("abort_addr3_kept", 64'(wmem[3]), 64'(6));
        chk("abort_all_writes", 64'(exp_q.size()), 64'(0));

        // abort and start together in IDLE: abort wins
        @(posedge clk); #1;
        start = 1; abort = 1; step(1); start = 0; abort = 0;
        @(negedge clk);
        chk("abort_start_busy", 64'({busy, mem_rd_en}), 64'(0));
        step(2);

        // reset mid-CALC
        start = 1; step(1); start = 0;
        step(2);
        chk("pre_reset_calc", 64'(man_enable), 64'(1));
        rst_n = 0; #1;
        chk("midreset_strobes", 64'({busy, done, mem_rd_en, mem_wr_en, man_enable}), 64'(0));
        chk("midreset_regs", 64'(man_eta | man_old_weight | man_diff_error | mem_wr_data), 64'(0));
        step(2);
        rst_n = 1;
        step(20);
        chk("midreset_addr0_kept", 64'(wmem[0]), 64'(4));

        // single-entry instance, one settle cycle
        eta1 = 34'h1_3DCCCCCD;
        begin
            wr_t x;
            x.addr = '0;
            x.data = W'(8);
            x.err  = W'(85);
            exp1_q.push_back(x);
        end
        start1 = 1; step(1); start1 = 0;
        wait_done(1, 4, 0, "done_single");
        chk("single_enable_cycles", 64'(en1_cnt), 64'(2));
        chk("single_reads", 64'(rd1_cnt), 64'(1));
        chk("single_all_writes", 64'(exp1_q.size()), 64'(0));
        chk("single_mem", 64'(w1), 64'(8));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
